// File: rtl/sync_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_cnt_pkg
// Description : Shared types and constants for the synchronous down counter.
//               Holds the counter state encoding and the default width.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_cnt_pkg;

  // IDLE : no count armed
  // RUN  : counting
  // DONE : reached zero in one-shot mode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam int CNT_WIDTH_DEFAULT = 4;

endpackage : sync_cnt_pkg
`default_nettype wire

// File: rtl/sync_down_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sync_down_cnt
// Description : Loadable synchronous down counter with a terminal-count pulse.
//               Priority per cycle is load > en > hold. In RUN with en the
//               counter decrements, wrapping modulo 2^WIDTH. tc pulses for one
//               cycle after a decrement from 1 to 0 (never after a load).
//               Build option SYNC_DOWN_ONESHOT_EN: reaching zero by decrement
//               parks the counter in DONE until the next load.
// Ports       :
//   clk      in   clock, all state changes on rising edge
//   reset    in   asynchronous active-low reset
//   en       in   count enable
//   load     in   synchronous load strobe
//   load_val in   [WIDTH] value captured on load
//   Q        out  [WIDTH] registered count
//   zero     out  Q == 0
//   tc       out  registered terminal-count pulse
//   busy     out  high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module sync_down_cnt
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

`ifdef SYNC_DOWN_ONESHOT_EN
  localparam bit c_oneshot = 1'b1;
`else
  localparam bit c_oneshot = 1'b0;
`endif

  cnt_state_t       r_state;
  cnt_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             w_dec;
  logic             w_dec_to_zero;

  // A decrement only happens in RUN and only when no load overrides it.
  assign w_dec         = (r_state == RUN) && en && !load;
  assign w_dec_to_zero = w_dec && (r_q == WIDTH'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      // A one-shot load of zero is already at terminal count.
      if (c_oneshot && (load_val == '0)) begin
        w_state_nxt = DONE;
      end else begin
        w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        RUN: begin
          if (c_oneshot && w_dec_to_zero) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          // Unreachable in wrap mode; fall back to IDLE if ever entered.
          w_state_nxt = c_oneshot ? DONE : IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counter and terminal-count registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      if (load) begin
        r_q <= load_val;
      end else if (w_dec) begin
        r_q <= r_q - WIDTH'(1);
      end
      r_tc <= w_dec_to_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (r_state == RUN);
  end

  assign Q    = r_q;
  assign zero = (r_q == '0);
  assign tc   = r_tc;

endmodule : sync_down_cnt
`default_nettype wire

// File: tb/tb_sync_down_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_down_cnt
// Description : Scoreboard testbench for sync_down_cnt (WIDTH=4). The driver
//               applies directed vectors at the falling edge and queues the
//               hand-computed response expected after the next rising edge;
//               a monitor pops and compares after each rising edge, or right
//               after an asynchronous reset event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_down_cnt;

  localparam int WIDTH = 4;

`ifdef SYNC_DOWN_ONESHOT_EN
  localparam bit c_os = 1'b1;
`else
  localparam bit c_os = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             zero;
  logic             tc;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event ev_async;

  sync_down_cnt #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .Q        (Q),
    .zero     (zero),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare after each rising edge or an async reset event.
  initial begin
    forever begin
      @(posedge clk or ev_async);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic ez;
        e  = exp_q.pop_front();
        ez = (e.q == '0);
        n_checks++;
        if (Q !== e.q || zero !== ez || tc !== e.tc || busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s: got Q=%0d zero=%b tc=%b busy=%b, want Q=%0d zero=%b tc=%b busy=%b",
                   e.tag, Q, zero, tc, busy, e.q, ez, e.tc, e.busy);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [WIDTH-1:0] q, input logic t,
                              input logic b, input string tag);
    exp_t e;
    e.q = q; e.tc = t; e.busy = b; e.tag = tag;
    return e;
  endfunction

  task automatic step(input logic ld, input logic [WIDTH-1:0] lv, input logic e,
                      input logic [WIDTH-1:0] eq, input logic etc, input logic eb,
                      input string tag);
    @(negedge clk);
    load     = ld;
    load_val = lv;
    en       = e;
    exp_q.push_back(mk(eq, etc, eb, tag));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;

    // Reset state while reset is held low.
    #12;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, "reset_state"));
    ->ev_async;
    @(negedge clk);
    reset = 1'b1;

    // IDLE ignores en; a load is needed to start.
    step(0, 4'd0, 1, 4'd0, 0, 0, "idle_en_ignored0");
    step(0, 4'd0, 1, 4'd0, 0, 0, "idle_en_ignored1");

    // Load 5 then count down to 0.
    step(1, 4'd5, 0, 4'd5, 0, 1, "load5");
    step(0, 4'd0, 1, 4'd4, 0, 1, "dec4");
    step(0, 4'd0, 1, 4'd3, 0, 1, "dec3");
    step(0, 4'd0, 1, 4'd2, 0, 1, "dec2");
    step(0, 4'd0, 1, 4'd1, 0, 1, "dec1");
    step(0, 4'd0, 1, 4'd0, 1, !c_os, "dec0_tc");

`ifdef SYNC_DOWN_ONESHOT_EN
    // DONE: en held high, Q stays 0, no further tc.
    for (int i = 0; i < 10; i++) begin
      step(0, 4'd0, 1, 4'd0, 0, 0, "done_hold");
    end
`else
    // Wrap: 0 -> 15 ... 1 -> 0 with a second tc.
    for (int i = 15; i >= 1; i--) begin
      step(0, 4'd0, 1, 4'(i), 0, 1, "wrap");
    end
    step(0, 4'd0, 1, 4'd0, 1, 1, "wrap_tc2");
`endif

    // Reload mid-count.
    step(1, 4'd5, 1, 4'd5, 0, 1, "reload5");
    step(0, 4'd0, 1, 4'd4, 0, 1, "rl_dec4");
    step(0, 4'd0, 1, 4'd3, 0, 1, "rl_dec3");
    step(1, 4'd9, 1, 4'd9, 0, 1, "reload9_at3");
    step(1, 4'd1, 0, 4'd1, 0, 1, "load1");
    step(1, 4'd6, 1, 4'd6, 0, 1, "load_vs_1to0");
    step(0, 4'd0, 0, 4'd6, 0, 1, "hold_no_tc");

    // Enable gating from 7: en 1,0,0,1.
    step(1, 4'd8, 0, 4'd8, 0, 1, "load8");
    step(0, 4'd0, 1, 4'd7, 0, 1, "gate_7");
    step(0, 4'd0, 1, 4'd6, 0, 1, "gate_en1");
    step(0, 4'd0, 0, 4'd6, 0, 1, "gate_en0a");
    step(0, 4'd0, 0, 4'd6, 0, 1, "gate_en0b");
    step(0, 4'd0, 1, 4'd5, 0, 1, "gate_en1b");

    // Load of zero: no tc.
    step(1, 4'd0, 0, 4'd0, 0, !c_os, "load0");
    step(0, 4'd0, 1, c_os ? 4'd0 : 4'd15, 0, !c_os, "after_load0");

    // Async reset mid-count at Q=4.
    step(1, 4'd4, 0, 4'd4, 0, 1, "load4");
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, "async_reset"));
    ->ev_async;
    @(negedge clk);
    reset = 1'b1;
    step(0, 4'd0, 1, 4'd0, 0, 0, "post_reset_idle0");
    step(0, 4'd0, 1, 4'd0, 0, 0, "post_reset_idle1");
    step(0, 4'd0, 1, 4'd0, 0, 0, "post_reset_idle2");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_down_cnt
`default_nettype wire
